// File: rtl/tick_gen_pkg.sv
// Shared timing constants and helpers for the tick generator, timers and blink logic.
package tick_gen_pkg;

   localparam int unsigned CNT_W_DEF        = 26;
   localparam int unsigned DEFAULT_HALF_DEF = 40_000_000;

   // Width of a channel index; never less than one bit so single-channel builds still have a port.
   function automatic int unsigned ch_idx_w(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick/square-wave channel: counter, active and staged half-period, tick strobe and square wave.
module tick_channel
   import tick_gen_pkg::*;
#(
   parameter int unsigned CNT_W        = CNT_W_DEF,
   parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sync,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             tick,
   output logic             sq,
   output logic             pending
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] next_half_q, next_half_d;
   logic [CNT_W-1:0] last_cnt;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;
   logic             pending_q, pending_d;
   logic             term;
   logic             apply;

   always_comb begin
      // A stored half-period of zero behaves as one.
      last_cnt = (half_q == '0) ? '0 : half_q - CNT_W'(1);
      term     = en && (cnt_q == last_cnt);
      apply    = pending_q && (term || !en || sync);

      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (sync || !en) begin
         cnt_d = '0;
         sq_d  = 1'b0;
      end else if (term) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         sq_d   = ~sq_q;
      end

      half_d      = apply ? next_half_q : half_q;
      next_half_d = next_half_q;
      pending_d   = pending_q;
      // cfg_we is only possible while nothing is pending, so it never collides with apply.
      if (cfg_we) begin
         next_half_d = cfg_half;
         pending_d   = 1'b1;
      end else if (apply) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         half_q      <= CNT_W'(DEFAULT_HALF);
         next_half_q <= '0;
         tick_q      <= 1'b0;
         sq_q        <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         half_q      <= half_d;
         next_half_q <= next_half_d;
         tick_q      <= tick_d;
         sq_q        <= sq_d;
         pending_q   <= pending_d;
      end
   end

   assign tick    = tick_q;
   assign sq      = sq_q;
   assign pending = pending_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel tick and square-wave generator: config decode, ready mux and sync fan-out.
module tick_generator
   import tick_gen_pkg::*;
#(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CNT_W        = CNT_W_DEF,
   parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
   localparam int unsigned CH_W        = ch_idx_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_half,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq,
   output logic [NUM_CH-1:0] pending
);

   logic [NUM_CH-1:0] cfg_we;

   // Out-of-range channel selects read as ready so the request is accepted and dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = !pending[i];
         end
      end
   end

   always_comb begin
      cfg_we = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_we[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tick_channel #(
         .CNT_W        (CNT_W),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .en       (en[g]),
         .sync     (sync),
         .cfg_we   (cfg_we[g]),
         .cfg_half (cfg_half),
         .tick     (tick[g]),
         .sq       (sq[g]),
         .pending  (pending[g])
      );
   end

endmodule

// File: tb/tb_tick_generator.sv
// Directed vector bench for tick_generator with two 8-bit channels and a default half-period of 3.
module tb_tick_generator;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned NVEC   = 45;

   logic              clk;
   logic              reset;
   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [0:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_half;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;
   logic [NUM_CH-1:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   tick_generator #(
      .NUM_CH       (NUM_CH),
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_half  (cfg_half),
      .tick      (tick),
      .sq        (sq),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [1:0] en;
      logic       sync;
      logic       cv;
      logic       ch;
      logic [7:0] half;
      logic       rdy;   // cfg_ready expected just before the edge
      logic [1:0] tick;  // registered outputs expected just after the edge
      logic [1:0] sq;
      logic [1:0] pend;
   } vec_t;

   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic r, input logic [1:0] e, input logic s, input logic v,
                               input logic c, input logic [7:0] h, input logic rd,
                               input logic [1:0] t, input logic [1:0] q, input logic [1:0] p);
      vec_t x;
      x.rst = r; x.en = e; x.sync = s; x.cv = v; x.ch = c; x.half = h;
      x.rdy = rd; x.tick = t; x.sq = q; x.pend = p;
      return x;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int edges;

      //               rst en    syn cv ch half  rdy tick   sq     pend
      // Channel 0 free-running at H=3
      vecs[0]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[1]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[2]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b01, 2'b01, 2'b00);
      vecs[3]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b01, 2'b00);
      vecs[4]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b01, 2'b00);
      vecs[5]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
      vecs[6]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[7]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[8]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b01, 2'b01, 2'b00);
      vecs[9]  = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b01, 2'b00);
      // Half=5 to ch0 at cnt=1; old period ends, then rejected rewrite, then ch1 write
      vecs[10] = mk(0, 2'b01, 0, 1, 0, 8'd5, 1, 2'b00, 2'b01, 2'b01);
      vecs[11] = mk(0, 2'b01, 0, 1, 0, 8'd7, 0, 2'b01, 2'b00, 2'b00);
      vecs[12] = mk(0, 2'b01, 0, 1, 1, 8'd2, 1, 2'b00, 2'b00, 2'b10);
      vecs[13] = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[14] = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[15] = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[16] = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b01, 2'b01, 2'b00);
      // Enable ch1 at H=2
      vecs[17] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b00, 2'b01, 2'b00);
      vecs[18] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b10, 2'b11, 2'b00);
      vecs[19] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b00, 2'b11, 2'b00);
      vecs[20] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b10, 2'b01, 2'b00);
      vecs[21] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b01, 2'b00, 2'b00);
      // Half=4 pending on ch0, then sync on its terminal-count edge
      vecs[22] = mk(0, 2'b11, 0, 1, 0, 8'd4, 1, 2'b10, 2'b10, 2'b01);
      vecs[23] = mk(0, 2'b11, 0, 0, 0, 8'd0, 0, 2'b00, 2'b10, 2'b01);
      vecs[24] = mk(0, 2'b11, 0, 0, 0, 8'd0, 0, 2'b10, 2'b00, 2'b01);
      vecs[25] = mk(0, 2'b11, 0, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b01);
      vecs[26] = mk(0, 2'b11, 1, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
      vecs[27] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[28] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b10, 2'b10, 2'b00);
      vecs[29] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b00, 2'b10, 2'b00);
      vecs[30] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b11, 2'b01, 2'b00);
      // Half=0 to ch0: continuous tick once applied
      vecs[31] = mk(0, 2'b11, 0, 1, 0, 8'd0, 1, 2'b00, 2'b01, 2'b01);
      vecs[32] = mk(0, 2'b11, 0, 0, 0, 8'd0, 0, 2'b10, 2'b11, 2'b01);
      vecs[33] = mk(0, 2'b11, 0, 0, 0, 8'd0, 0, 2'b00, 2'b11, 2'b01);
      vecs[34] = mk(0, 2'b11, 0, 0, 0, 8'd0, 0, 2'b11, 2'b00, 2'b00);
      vecs[35] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b01, 2'b01, 2'b00);
      vecs[36] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b11, 2'b10, 2'b00);
      vecs[37] = mk(0, 2'b11, 0, 0, 0, 8'd0, 1, 2'b01, 2'b11, 2'b00);
      vecs[38] = mk(0, 2'b00, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      // Re-enable with a write so sq=1 and pending=1, then reset (with sync) wins
      vecs[39] = mk(0, 2'b01, 0, 1, 0, 8'd9, 1, 2'b01, 2'b01, 2'b01);
      vecs[40] = mk(1, 2'b01, 1, 0, 0, 8'd0, 0, 2'b00, 2'b00, 2'b00);
      vecs[41] = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[42] = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b00, 2'b00);
      vecs[43] = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b01, 2'b01, 2'b00);
      vecs[44] = mk(0, 2'b01, 0, 0, 0, 8'd0, 1, 2'b00, 2'b01, 2'b00);

      reset = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset tick",    8'(tick),      8'h00);
      check("reset sq",      8'(sq),        8'h00);
      check("reset pending", 8'(pending),   8'h00);
      check("reset ready",   8'(cfg_ready), 8'h01);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         reset     = vecs[i].rst;
         en        = vecs[i].en;
         sync      = vecs[i].sync;
         cfg_valid = vecs[i].cv;
         cfg_ch    = vecs[i].ch;
         cfg_half  = vecs[i].half;
         #1;
         check($sformatf("v%0d cfg_ready", i), 8'(cfg_ready), 8'(vecs[i].rdy));
         @(posedge clk);
         #1;
         check($sformatf("v%0d tick", i),    8'(tick),    8'(vecs[i].tick));
         check($sformatf("v%0d sq", i),      8'(sq),      8'(vecs[i].sq));
         check($sformatf("v%0d pending", i), 8'(pending), 8'(vecs[i].pend));
      end

      // First-tick latency after reset: tick[0] must appear after exactly 3 enabled edges.
      @(negedge clk);
      reset = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0; en = 2'b01;
      edges = 0;
      while (edges < 10) begin
         @(posedge clk);
         #1;
         edges++;
         if (tick[0]) break;
      end
      check("first tick latency", 8'(edges), 8'd3);
      check("first tick ch1 idle", 8'(tick[1]), 8'h00);

      // Disable mid-count: everything clears on the next edge and restarts from phase 0.
      @(negedge clk);
      en = 2'b00;
      @(posedge clk);
      #1;
      check("disable tick", 8'(tick), 8'h00);
      check("disable sq",   8'(sq),   8'h00);
      @(negedge clk);
      en = 2'b01;
      repeat (2) @(posedge clk);
      #1;
      check("restart no early tick", 8'(tick), 8'h00);
      @(posedge clk);
      #1;
      check("restart tick", 8'(tick), 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tick_generator.md
# tick_generator

Parametrised multi-channel tick and square-wave generator that supersedes the fixed 1 Hz / 2 Hz divider in the parking-system timing path. Each channel has its own runtime-programmable half-period, an enable, a one-cycle tick strobe and a 50 % square wave. A global sync input phase-aligns all channels. Display blink, gate timers and debouncers consume `tick` as a clock enable; no derived clocks leave the block.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 26: counter and half-period width in bits.
- `DEFAULT_HALF`, 40_000_000: half-period loaded into every channel at reset, in `clk` cycles.
- `clk` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `en` in NUM_CH: per-channel run enable.
- `sync` in 1: one-cycle strobe that restarts every channel's phase.
- `cfg_valid` in 1: half-period update request.
- `cfg_ready` out 1: update can be accepted for the channel selected by `cfg_ch`.
- `cfg_ch` in clog2(NUM_CH), minimum 1: target channel.
- `cfg_half` in CNT_W: new half-period.
- `tick` out NUM_CH: one-cycle pulse at every half-period boundary.
- `sq` out NUM_CH: square wave that toggles on every tick.
- `pending` out NUM_CH: channel holds an accepted but not yet applied half-period.

## Operation
- Effective half-period: `H = max(half[i], 1)`. A stored value of 0 behaves as 1.
- Enabled channel (`en[i]=1`, no `sync`): `cnt` increments each cycle. When `cnt == H-1`, on the next edge:
  - `cnt` goes to 0.
  - `tick[i]` goes to 1 for that cycle only.
  - `sq[i]` inverts.
- Square-wave period is `2*H` cycles. With `H=1`, `tick` stays high continuously and `sq` toggles every cycle.
- Disabled channel: `cnt`, `tick` and `sq` are forced to 0. Re-enabling starts from phase 0.
- Config handshake:
  - Transfer occurs on an edge where `cfg_valid && cfg_ready`.
  - `cfg_ready = !pending[cfg_ch]`, combinational from `cfg_ch`. If `cfg_ch >= NUM_CH`, `cfg_ready` is 1 and the request is accepted and dropped.
  - On acceptance, `cfg_half` is stored in `next_half[cfg_ch]` and `pending[cfg_ch]` is set.
- Glitch-free apply: a pending value is copied into `half[i]` and `pending[i]` clears on the first edge where any of these holds:
  - the channel reaches its terminal count;
  - `en[i]=0`;
  - `sync=1`.
  The period in progress always completes with the old value.
- `sync`: on that edge every channel sets `cnt=0`, `sq=0`, `tick=0` and applies any pending value. `sync` overrides a coincident terminal count, so no tick is produced on that edge.
- Counter arithmetic is unsigned CNT_W. Compare is equality against `H-1`, so no overflow is possible. An `H` change never leaves `cnt` above the new `H-1`, because the apply only occurs with `cnt` returning to 0.

## Timing
- Reset values (all outputs and state):
  - `cnt=0`, `half=DEFAULT_HALF`, `next_half=0`.
  - `tick=0`, `sq=0`, `pending=0`.
  - `cfg_ready=1` from the first cycle after reset.
- Reset mid-operation discards pending updates and restores `DEFAULT_HALF`.
- Latency: with `en[i]` sampled high at edges 1, 2, …, the first `tick[i]` is high in the cycle following edge `H`. Subsequent ticks follow every `H` edges.
- `tick`, `sq` and `pending` are registered. `cfg_ready` is the only combinational output.
- A config accepted on edge k sets `pending` visible from k+1. With a terminal count on edge k+1, the new `H` governs the period starting after edge k+1.
- Simultaneous events:
  - Config acceptance and terminal count on the same edge: the old `next_half` is not overwritten (cfg_ready was 0 if pending). The newly accepted value waits for the next terminal count.
  - `reset` beats `sync`, and `sync` beats `en`.

## Structure
- `tick_gen_pkg` holds `DEFAULT_HALF`, the `CNT_W` default and the channel-index width function shared with timer and blink blocks.
- One sub-module, `tick_channel`, contains a single channel's counter, half/next_half/pending registers, tick and sq. It is instantiated NUM_CH times in a generate loop.
- The top level holds only `cfg_ch` decode, `cfg_ready` mux and `sync` fan-out.

## Test plan
All scenarios use NUM_CH=2, CNT_W=8, DEFAULT_HALF=3.
- Reset release with en=2'b01 → `tick[0]` high after edges 3, 6, 9; `sq[0]` toggles at each tick, giving a 6-cycle period; channel 1 outputs stay 0.
- Write `cfg_half=5` to ch0 mid-period (cnt=1) → `pending[0]=1` and `cfg_ready` low for ch0. The current period still ends at edge count 3; later ticks are spaced 5 apart and `pending` clears at the switch.
- Second write to ch0 while pending → `cfg_ready=0` and the value is not accepted. A write to ch1 in the same cycle is accepted.
- Assert `sync` on a terminal-count edge of ch0 → no tick, `cnt=0`, `sq=0` on both channels, and the pending value is applied. The next tick comes H edges later.
- Write `cfg_half=0` → `tick` held high every cycle and `sq` toggles every cycle. Drop `en` → all outputs go to 0 the next cycle.
- Assert `reset` while `pending=1` and `sq=1` → after one edge all outputs are 0, H returns to 3 and `cfg_ready=1`.
